// File: rtl/apprx_err_accum_if.sv
// Bus between the approximate multiplier tap and the error accumulator.
// Carries run control, sample handshake and the accumulated statistics.
interface apprx_err_accum_if #(
  parameter int W     = 8,
  parameter int CNT_W = 32
);
  logic                   start;
  logic [CNT_W-1:0]       num_samples;
  logic                   in_valid;
  logic                   in_ready;
  logic [W-1:0]           dat_in_a;
  logic [W-1:0]           dat_in_b;
  logic [2*W-1:0]         dat_apprx;
  logic                   busy;
  logic                   done;
  logic [CNT_W-1:0]       sample_cnt;
  logic [CNT_W-1:0]       err_cnt;
  logic [2*W+CNT_W-1:0]   sum_abs_ed;
  logic [2*W+CNT_W:0]     sum_ed;
  logic [2*W-1:0]         max_ed;

  modport master (
    output start, num_samples, in_valid,
    output dat_in_a, dat_in_b, dat_apprx,
    input  in_ready, busy, done,
    input  sample_cnt, err_cnt,
    input  sum_abs_ed, sum_ed, max_ed
  );

  modport slave (
    input  start, num_samples, in_valid,
    input  dat_in_a, dat_in_b, dat_apprx,
    output in_ready, busy, done,
    output sample_cnt, err_cnt,
    output sum_abs_ed, sum_ed, max_ed
  );
endinterface

// File: rtl/apprx_err_accum.sv
// Error-metric accumulator: recomputes the exact product and
// gathers ER/MED/WCE raw statistics over a run of N samples.
module apprx_err_accum #(
  parameter int W     = 8,
  parameter int CNT_W = 32
) (
  input  logic clk,
  input  logic rst_n,
  apprx_err_accum_if.slave bus
);
  localparam int P  = 2 * W;
  localparam int SW = P + CNT_W;
  localparam int EW = P + CNT_W + 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]       r_state;
  logic [1:0]       r_drain_cnt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_acc_cnt;
  logic             r_in_ready;

  logic             r_s1_vld;
  logic [W-1:0]     r_s1_a;
  logic [W-1:0]     r_s1_b;
  logic [P-1:0]     r_s1_p;

  logic             r_s2_vld;
  logic [P:0]       r_s2_ed;
  logic [P-1:0]     r_s2_abs;
  logic             r_s2_neq;

  logic [CNT_W-1:0] r_sample_cnt;
  logic [CNT_W-1:0] r_err_cnt;
  logic [SW-1:0]    r_sum_abs;
  logic [EW-1:0]    r_sum_ed;
  logic [P-1:0]     r_max;

  logic             w_idle;
  logic             w_run;
  logic             w_drain;
  logic             w_done;
  logic             w_start;
  logic             w_accept;
  logic [CNT_W-1:0] w_acc_nxt;
  logic [P-1:0]     w_exact;
  logic [P:0]       w_ed;
  logic [P:0]       w_ed_neg;
  logic [P-1:0]     w_abs;
  logic             w_neq;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_run    = (r_state == ST_RUN);
  assign w_drain  = (r_state == ST_DRAIN);
  assign w_done   = (r_state == ST_DONE);

  // start only launches a run from IDLE or DONE
  assign w_start  = bus.start & (w_idle | w_done);
  // in_ready is registered and only ever high in RUN
  assign w_accept = bus.in_valid & r_in_ready;
  assign w_acc_nxt = r_acc_cnt + CNT_W'(1);

  assign w_exact  = {{W{1'b0}}, r_s1_a} * {{W{1'b0}}, r_s1_b};
  assign w_ed     = {1'b0, w_exact} - {1'b0, r_s1_p};
  assign w_ed_neg = -w_ed;
  assign w_abs    = w_ed[P] ? w_ed_neg[P-1:0] : w_ed[P-1:0];
  assign w_neq    = (w_exact != r_s1_p);

  // run control: sample budget, accept window and drain timer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_drain_cnt <= 2'd0;
      r_n         <= '0;
      r_acc_cnt   <= '0;
      r_in_ready  <= 1'b0;
    end else begin
      unique case (1'b1)
        (w_idle | w_done): begin
          if (w_start) begin
            r_n         <= bus.num_samples;
            r_acc_cnt   <= '0;
            r_drain_cnt <= 2'd0;
            if (bus.num_samples == '0) begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
            end else begin
              r_state    <= ST_RUN;
              r_in_ready <= 1'b1;
            end
          end
        end
        w_run: begin
          if (w_accept) begin
            r_acc_cnt <= w_acc_nxt;
            if (w_acc_nxt == r_n) begin
              r_state     <= ST_DRAIN;
              r_in_ready  <= 1'b0;
              r_drain_cnt <= 2'd0;
            end
          end
        end
        w_drain: begin
          if (r_drain_cnt == 2'd1) begin
            r_state <= ST_DONE;
          end else begin
            r_drain_cnt <= r_drain_cnt + 2'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // stage 1: capture the accepted operand/product triple
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_s1_vld <= 1'b0;
      r_s1_a   <= '0;
      r_s1_b   <= '0;
      r_s1_p   <= '0;
    end else begin
      r_s1_vld <= w_accept;
      if (w_accept) begin
        r_s1_a <= bus.dat_in_a;
        r_s1_b <= bus.dat_in_b;
        r_s1_p <= bus.dat_apprx;
      end
    end
  end

  // stage 2: exact product, signed error distance and magnitude
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_s2_vld <= 1'b0;
      r_s2_ed  <= '0;
      r_s2_abs <= '0;
      r_s2_neq <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld;
      if (r_s1_vld) begin
        r_s2_ed  <= w_ed;
        r_s2_abs <= w_abs;
        r_s2_neq <= w_neq;
      end
    end
  end

  // stage 3: fold each sample into the run statistics
  always_ff @(posedge clk) begin
    if (!rst_n || w_start) begin
      r_sample_cnt <= '0;
      r_err_cnt    <= '0;
      r_sum_abs    <= '0;
      r_sum_ed     <= '0;
      r_max        <= '0;
    end else if (r_s2_vld) begin
      r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      if (r_s2_neq) begin
        r_err_cnt <= r_err_cnt + CNT_W'(1);
        r_sum_abs <= r_sum_abs + {{(SW-P){1'b0}}, r_s2_abs};
        r_sum_ed  <= r_sum_ed +
                     {{(EW-P-1){r_s2_ed[P]}}, r_s2_ed};
        if (r_s2_abs > r_max) begin
          r_max <= r_s2_abs;
        end
      end
    end
  end

  assign bus.in_ready   = r_in_ready;
  assign bus.busy       = w_run | w_drain;
  assign bus.done       = w_done;
  assign bus.sample_cnt = r_sample_cnt;
  assign bus.err_cnt    = r_err_cnt;
  assign bus.sum_abs_ed = r_sum_abs;
  assign bus.sum_ed     = r_sum_ed;
  assign bus.max_ed     = r_max;
endmodule

// File: tb/tb_apprx_err_accum.sv
// Bench for apprx_err_accum: table-driven runs, hand-built
// corner sequences and random runs against an arithmetic model.
module tb_apprx_err_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  apprx_err_accum_if #(.W(8), .CNT_W(32)) bus ();

  apprx_err_accum #(.W(8), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int               n;
    logic [3:0][7:0]  a;
    logic [3:0][7:0]  b;
    logic [3:0][15:0] p;
    longint           e_err;
    longint           e_sabs;
    longint           e_sed;
    longint           e_max;
  } vec_t;

  vec_t tv [7];

  logic [7:0]  qa [$];
  logic [7:0]  qb [$];
  logic [15:0] qp [$];

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic chk_stats(input string nm, input longint n,
                           input longint e_err, input longint e_sabs,
                           input longint e_sed, input longint e_max);
    chk({nm, ".sample_cnt"}, longint'(bus.sample_cnt), n);
    chk({nm, ".err_cnt"}, longint'(bus.err_cnt), e_err);
    chk({nm, ".sum_abs_ed"}, longint'(bus.sum_abs_ed), e_sabs);
    chk({nm, ".sum_ed"}, longint'($signed(bus.sum_ed)), e_sed);
    chk({nm, ".max_ed"}, longint'(bus.max_ed), e_max);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // gm: 0 back-to-back, 1 one idle cycle between samples, 2 random gaps
  task automatic run(input string nm, input int gm, input bit hold,
                     input longint e_err, input longint e_sabs,
                     input longint e_sed, input longint e_max);
    int n;
    n = qa.size();
    bus.start = 1'b1;
    bus.num_samples = n;
    tick();
    bus.start = 1'b0;
    bus.num_samples = 32'hdead_beef;
    if (n == 0) begin
      chk({nm, ".done0"}, longint'(bus.done), 1);
      chk({nm, ".rdy0"}, longint'(bus.in_ready), 0);
      chk({nm, ".busy0"}, longint'(bus.busy), 0);
    end else begin
      chk({nm, ".rdy1"}, longint'(bus.in_ready), 1);
      chk({nm, ".busy1"}, longint'(bus.busy), 1);
    end
    for (int i = 0; i < n; i++) begin
      bit ok;
      bit rdy;
      int g;
      if ((gm == 1 && i > 0) || (gm == 2 && $urandom_range(0, 3) == 0)) begin
        bus.in_valid = 1'b0;
        bus.dat_in_a = 8'($urandom);
        bus.dat_in_b = 8'($urandom);
        bus.dat_apprx = 16'($urandom);
        tick();
      end
      bus.in_valid = 1'b1;
      bus.dat_in_a = qa[i];
      bus.dat_in_b = qb[i];
      bus.dat_apprx = qp[i];
      ok = 1'b0;
      g = 0;
      while (!ok && g < 20) begin
        rdy = bus.in_ready;
        tick();
        ok = rdy;
        g++;
      end
      if (!ok) chk({nm, ".accept_timeout"}, 0, 1);
    end
    bus.in_valid = hold;
    if (n != 0) begin
      chk({nm, ".done_k"}, longint'(bus.done), 0);
      chk({nm, ".rdy_k"}, longint'(bus.in_ready), 0);
      tick();
      chk({nm, ".done_k1"}, longint'(bus.done), 0);
      tick();
      chk({nm, ".done_k2"}, longint'(bus.done), 1);
      chk({nm, ".busy_k2"}, longint'(bus.busy), 0);
    end
    chk_stats(nm, n, e_err, e_sabs, e_sed, e_max);
    if (hold) begin
      repeat (3) tick();
      chk({nm, ".rdy_hold"}, longint'(bus.in_ready), 0);
      chk({nm, ".cnt_hold"}, longint'(bus.sample_cnt), n);
    end
    bus.in_valid = 1'b0;
    qa.delete();
    qb.delete();
    qp.delete();
  endtask

  task automatic load_vec(input vec_t v);
    for (int i = 0; i < v.n; i++) begin
      qa.push_back(v.a[i]);
      qb.push_back(v.b[i]);
      qp.push_back(v.p[i]);
    end
  endtask

  initial begin
    longint m_err, m_sabs, m_sed, m_max;

    tv[0] = '{3, {8'd0, 8'd0, 8'd255, 8'd3}, {8'd0, 8'd7, 8'd255, 8'd5},
              {16'd0, 16'd0, 16'd65025, 16'd15}, 0, 0, 0, 0};
    tv[1] = '{2, {8'd0, 8'd0, 8'd16, 8'd10}, {8'd0, 8'd0, 8'd16, 8'd10},
              {16'd0, 16'd0, 16'd260, 16'd96}, 2, 8, 0, 4};
    tv[2] = '{0, '0, '0, '0, 0, 0, 0, 0};
    tv[3] = '{1, '0, '0, {16'd0, 16'd0, 16'd0, 16'd65535},
              1, 65535, -65535, 65535};
    tv[4] = '{2, {8'd0, 8'd0, 8'd4, 8'd200}, {8'd0, 8'd0, 8'd4, 8'd3},
              {16'd0, 16'd0, 16'd10, 16'd610}, 2, 16, -4, 10};
    tv[5] = '{3, {8'd0, 8'd1, 8'd3, 8'd2}, {8'd0, 8'd1, 8'd3, 8'd2},
              {16'd0, 16'd0, 16'd6, 16'd1}, 3, 7, 7, 3};
    tv[6] = '{2, {8'd0, 8'd0, 8'd255, 8'd255}, {8'd0, 8'd0, 8'd255, 8'd255},
              {16'd0, 16'd0, 16'd65535, 16'd0}, 2, 65535, 64515, 65025};

    bus.start = 1'b0;
    bus.num_samples = '0;
    bus.in_valid = 1'b0;
    bus.dat_in_a = '0;
    bus.dat_in_b = '0;
    bus.dat_apprx = '0;

    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst.in_ready", longint'(bus.in_ready), 0);
    chk("rst.busy", longint'(bus.busy), 0);
    chk("rst.done", longint'(bus.done), 0);
    chk_stats("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 7; t++) begin
      load_vec(tv[t]);
      run($sformatf("tv%0d", t), 0, 1'b0,
          tv[t].e_err, tv[t].e_sabs, tv[t].e_sed, tv[t].e_max);
      tick();
    end

    qa = '{8'd1, 8'd2, 8'd3, 8'd4};
    qb = '{8'd1, 8'd2, 8'd3, 8'd4};
    qp = '{16'd1, 16'd4, 16'd9, 16'd16};
    run("toggle", 1, 1'b1, 0, 0, 0, 0);

    bus.start = 1'b1;
    bus.num_samples = 5;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.dat_in_a = 8'd9;
    bus.dat_in_b = 8'd9;
    bus.dat_apprx = 16'd1;
    repeat (2) tick();
    bus.in_valid = 1'b0;
    repeat (2) tick();
    chk("midrst.pre_cnt", longint'(bus.sample_cnt), 2);
    chk("midrst.pre_busy", longint'(bus.busy), 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst.busy", longint'(bus.busy), 0);
    chk("midrst.done", longint'(bus.done), 0);
    chk("midrst.rdy", longint'(bus.in_ready), 0);
    chk_stats("midrst", 0, 0, 0, 0, 0);
    tick();
    qa = '{8'd2};
    qb = '{8'd3};
    qp = '{16'd5};
    run("after_rst", 0, 1'b0, 1, 1, 1, 1);

    for (int r = 0; r < 15; r++) begin
      int n;
      n = $urandom_range(1, 8);
      m_err = 0;
      m_sabs = 0;
      m_sed = 0;
      m_max = 0;
      for (int i = 0; i < n; i++) begin
        longint ex, ap, d;
        qa.push_back(8'($urandom));
        qb.push_back(8'($urandom));
        ex = longint'(qa[i]) * longint'(qb[i]);
        case ($urandom_range(0, 2))
          0: qp.push_back(16'(ex));
          1: qp.push_back(16'(ex + $urandom_range(0, 40) - 20));
          default: qp.push_back(16'($urandom));
        endcase
        ap = longint'(qp[i]);
        d = ex - ap;
        if (d != 0) m_err++;
        m_sabs += (d < 0) ? -d : d;
        m_sed += d;
        if (((d < 0) ? -d : d) > m_max) m_max = (d < 0) ? -d : d;
      end
      run($sformatf("rnd%0d", r), 2, 1'b0, m_err, m_sabs, m_sed, m_max);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
